// File: rtl/serial_frame_pkg.sv
// Shared definitions for the framed serial transmitter: FSM state codes and line levels.
package serial_frame_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_DATA  = 2'd2;
    localparam state_t ST_STOP  = 2'd3;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Per-bit cycle counter: counts 0..BIT_CYCLES-1 while enabled and flags the last cycle of a bit.
module bit_timer
    import serial_frame_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic [7:0] cnt_o,
    output logic       tick_o
);

    localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;

    assign tick_o = en && (cnt_q == LAST);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (en) begin
            cnt_d = tick_o ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out framed transmitter: start bit, WIDTH data bits LSB first, stop bit.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    input  logic             load,
    output logic             ready,
    output logic             Q,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [7:0] STOP_LAST  = (BIT_CYCLES > 1) ? 8'(BIT_CYCLES - 2) : 8'd0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             q_q, q_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tmr_en, tmr_clr, tick;
    logic [7:0]       cnt;

    bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .en    (tmr_en),
        .clr   (tmr_clr),
        .cnt_o (cnt),
        .tick_o(tick)
    );

    // The done cycle doubles as the final stop-bit cycle, so STOP itself lasts BIT_CYCLES-1
    // cycles; this lets a word loaded during done start its frame with no idle gap.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        done_d  = 1'b0;
        tmr_en  = (state_q != ST_IDLE);
        tmr_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                if (load) begin
                    shreg_d = D;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        if (BIT_CYCLES == 1) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            default: begin
                if (cnt == STOP_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase

        case (state_d)
            ST_START: q_d = START_BIT;
            ST_DATA:  q_d = shreg_d[0];
            ST_STOP:  q_d = STOP_BIT;
            default:  q_d = LINE_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            q_q     <= LINE_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            q_q     <= q_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Q     = q_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
